reg_seq_ctrl: RTL and testbench

- Fetch/decode/execute sequencer for the 16-bit CPU core.
- Fetches instruction words from memory through a req/ack handshake and loads them into the instruction register (register-file address 7).
- Decodes the instruction held in the register file and issues one general-purpose register write per instruction, sourced from an immediate, a memory read, or the ALU result.
- Owns the PC, sits between the memory interface and the register file, and provides run/halt control.

---
 rtl/reg_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_reg_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_seq_ctrl.sv
// reg_seq_ctrl: fetch/decode/execute sequencer for the 16-bit core; owns the PC,
// drives the memory read handshake and issues one register-file write per step.
module reg_seq_ctrl #(
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    input  logic [15:0]       ir,
    input  logic [15:0]       alu_result,
    output logic [2:0]        alu_op,
    output logic              rf_we,
    output logic [2:0]        rf_waddr,
    output logic [15:0]       rf_wdata,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEMRD, HALT} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] pc_n;
    logic [2:0] waddr_q;
    logic [15:0] wdata_q;
    logic err_n;
    logic [3:0] opc;
    logic [2:0] rd;
    logic bad;
    assign opc = ir[15:12];
    assign rd = ir[11:9];
    assign bad = !(opc inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF})
               || ((opc inside {4'h1, 4'h2, 4'h3}) && rd == 3'd7);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc <= RESET_PC;
            err <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            err <= err_n;
            if (rf_we) begin
                waddr_q <= rf_waddr;
                wdata_q <= rf_wdata;
            end
        end
    end
    // write address/data are muxed live on the strobe cycle and hold otherwise
    always_comb begin
        state_n = state;
        pc_n = pc;
        err_n = err;
        mem_req = 1'b0;
        mem_addr = '0;
        rf_we = 1'b0;
        rf_waddr = waddr_q;
        rf_wdata = wdata_q;
        alu_op = 3'd0;
        halted = 1'b0;
        case (state)
            IDLE: if (run) begin
                state_n = FETCH;
                pc_n = RESET_PC;
            end
            FETCH: begin
                mem_req = 1'b1;
                mem_addr = pc;
                if (mem_ack) begin
                    rf_we = 1'b1;
                    rf_waddr = 3'd7;
                    rf_wdata = mem_rdata;
                    pc_n = pc + 1'b1;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                state_n = bad ? HALT : EXEC;
                err_n = err | bad;
            end
            EXEC: begin
                alu_op = ir[8:6];
                state_n = run ? FETCH : IDLE;
                case (opc)
                    4'h1: begin
                        rf_we = 1'b1;
                        rf_waddr = rd;
                        rf_wdata = {7'b0, ir[8:0]};
                    end
                    4'h2: state_n = MEMRD;
                    4'h3: begin
                        rf_we = 1'b1;
                        rf_waddr = rd;
                        rf_wdata = alu_result;
                    end
                    4'h4: pc_n = ADDR_W'(ir[11:0]);
                    4'hF: state_n = HALT;
                    default: ;
                endcase
            end
            MEMRD: begin
                mem_req = 1'b1;
                mem_addr = ADDR_W'(ir[8:0]);
                if (mem_ack) begin
                    rf_we = 1'b1;
                    rf_waddr = rd;
                    rf_wdata = mem_rdata;
                    state_n = run ? FETCH : IDLE;
                end
            end
            HALT: begin
                halted = 1'b1;
                if (!run) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_reg_seq_ctrl.sv
// tb_reg_seq_ctrl: directed scoreboard bench for reg_seq_ctrl with a memory,
// IR register and ALU stand-in around the sequencer.
module tb_reg_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic mem_req, mem_ack, rf_we, halted, err;
    logic [15:0] mem_addr, mem_rdata, ir, alu_result, rf_wdata, pc;
    logic [2:0] alu_op, rf_waddr;
    logic run2 = 1'b0;
    logic mem_req2, rf_we2, halted2, err2;
    logic [15:0] mem_addr2, mem_rdata2, ir2, rf_wdata2, pc2;
    logic [2:0] alu_op2, rf_waddr2;
    logic [15:0] zero16 = 16'h0;
    logic [15:0] mem [0:65535];
    logic m_ack = 1'b0, m_ack2 = 1'b0, ext_ack = 1'b0;
    int ack_dly = 0, acnt = 0;
    int cyc = 0, t0 = 0;
    int vectors = 0, miscompares = 0;
    typedef struct {int c; logic [2:0] a; logic [15:0] d;} exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    reg_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .alu_result(alu_result),
        .alu_op(alu_op), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc(pc), .halted(halted), .err(err)
    );
    reg_seq_ctrl #(.RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst_n(rst_n), .run(run2), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ack(m_ack2), .mem_rdata(mem_rdata2), .ir(ir2), .alu_result(zero16),
        .alu_op(alu_op2), .rf_we(rf_we2), .rf_waddr(rf_waddr2), .rf_wdata(rf_wdata2),
        .pc(pc2), .halted(halted2), .err(err2)
    );

    assign mem_rdata = mem[mem_addr];
    assign mem_rdata2 = mem[mem_addr2];
    assign mem_ack = m_ack | ext_ack;
    assign alu_result = 16'h1230 | {13'b0, alu_op};

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rf_we === 1'b1 && rf_waddr == 3'd7) ir <= rf_wdata;
    always @(posedge clk) if (rf_we2 === 1'b1 && rf_waddr2 == 3'd7) ir2 <= rf_wdata2;

    // memory responder: ack after ack_dly waiting cycles of a held request
    always @(posedge clk) begin
        #1;
        if (mem_req === 1'b1) begin
            m_ack = (acnt == ack_dly);
            acnt = m_ack ? 0 : acnt + 1;
        end else begin
            m_ack = 1'b0;
            acnt = 0;
        end
        m_ack2 = (mem_req2 === 1'b1);
    end

    always @(negedge clk) if (rf_we === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: cyc=%0d waddr=%0d wdata=%h, required no write", cyc - t0, rf_waddr, rf_wdata);
        end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.c != cyc || e.a != rf_waddr || e.d != rf_wdata) begin
                miscompares++;
                $display("FAIL rf_write: got cyc=%0d waddr=%0d wdata=%h, required cyc=%0d waddr=%0d wdata=%h",
                         cyc - t0, rf_waddr, rf_wdata, e.c - t0, e.a, e.d);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [2:0] a, input logic [15:0] d);
        exp_t e;
        e.c = t0 + k;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic at(input int k);
        while (cyc < t0 + k) @(negedge clk);
    endtask

    task automatic do_reset();
        run = 1'b0;
        run2 = 1'b0;
        ext_ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start();
        run = 1'b1;
        t0 = cyc;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        ir = 16'h0;
        ir2 = 16'h0;
        do_reset();
        chk("rst_mem_req", {31'b0, mem_req}, 0);
        chk("rst_rf_we", {31'b0, rf_we}, 0);
        chk("rst_err_halted", {30'b0, err, halted}, 0);
        chk("rst_alu_op", {29'b0, alu_op}, 0);
        chk("rst_waddr_wdata", {13'b0, rf_waddr, rf_wdata}, 0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 0);
        chk("rst_pc", {16'b0, pc}, 0);
        chk("rst_pc2", {16'b0, pc2}, 32'h0000FFFF);

        // LDI, ALU, HLT with zero-wait memory
        mem[0] = 16'h1205; mem[1] = 16'h34C0; mem[2] = 16'hF000;
        start();
        push(1, 3'd7, 16'h1205); push(3, 3'd1, 16'h0005); push(4, 3'd7, 16'h34C0);
        push(6, 3'd2, 16'h1233); push(7, 3'd7, 16'hF000);
        at(2); chk("hold_waddr_wdata", {13'b0, rf_waddr, rf_wdata}, {13'b0, 3'd7, 16'h1205});
        at(3); chk("ldi_pc", {16'b0, pc}, 1);
        at(5); chk("alu_op_decode", {29'b0, alu_op}, 0);
        at(6); chk("alu_op_exec", {29'b0, alu_op}, 3);
        at(10); chk("hlt_halted", {31'b0, halted}, 1);
        chk("hlt_pc", {16'b0, pc}, 3);
        run = 1'b0;
        at(11); chk("hlt_to_idle", {31'b0, halted}, 0);

        // LD with a 3-cycle ack delay on both fetch and data read
        do_reset();
        ack_dly = 3;
        mem[0] = 16'h2A10; mem[1] = 16'hF000; mem[16'h0010] = 16'hBEEF;
        start();
        push(4, 3'd7, 16'h2A10); push(10, 3'd5, 16'hBEEF); push(14, 3'd7, 16'hF000);
        for (int k = 7; k <= 10; k++) begin
            at(k);
            chk("ld_req_addr", {15'b0, mem_req, mem_addr}, {15'b0, 1'b1, 16'h0010});
        end
        at(17); chk("ld_halted", {31'b0, halted}, 1);
        run = 1'b0;
        ack_dly = 0;

        // JMP to 0x123 which holds HLT
        do_reset();
        mem[0] = 16'h4123; mem[16'h0123] = 16'hF000;
        start();
        push(1, 3'd7, 16'h4123); push(4, 3'd7, 16'hF000);
        at(4); chk("jmp_fetch", {15'b0, mem_req, mem_addr}, {15'b0, 1'b1, 16'h0123});
        chk("jmp_pc", {16'b0, pc}, 32'h0123);
        at(8); chk("jmp_halted", {31'b0, halted}, 1);
        chk("jmp_pc_after", {16'b0, pc}, 32'h0124);
        run = 1'b0;
        at(9); chk("jmp_idle", {31'b0, halted}, 0);

        // illegal opcode: sticky err across run toggling
        do_reset();
        mem[0] = 16'h7000;
        start();
        push(1, 3'd7, 16'h7000); push(5, 3'd7, 16'h7000);
        at(3); chk("ill_err_halted", {30'b0, err, halted}, 3);
        run = 1'b0;
        at(4); chk("ill_idle_err", {30'b0, err, halted}, 2);
        run = 1'b1;
        at(7); chk("ill_again", {30'b0, err, halted}, 3);
        do_reset();
        chk("ill_reset_clears", {30'b0, err, halted}, 0);

        // LDI into rd=7 is illegal
        mem[0] = 16'h1E01;
        start();
        push(1, 3'd7, 16'h1E01);
        at(3); chk("rd7_err_halted", {30'b0, err, halted}, 3);
        do_reset();

        // PC wrap on the instance whose reset PC is all-ones
        mem[0] = 16'h0000; mem[16'hFFFF] = 16'h0000;
        run2 = 1'b1;
        t0 = cyc;
        at(1); chk("wrap_fetch_ffff", {15'b0, mem_req2, mem_addr2}, {15'b0, 1'b1, 16'hFFFF});
        at(2); chk("wrap_pc", {16'b0, pc2}, 0);
        at(4); chk("wrap_fetch_0", {15'b0, mem_req2, mem_addr2}, {15'b0, 1'b1, 16'h0000});
        run2 = 1'b0;
        at(7);

        // reset during a pending fetch, then a stray ack
        do_reset();
        ack_dly = 10;
        start();
        at(2); chk("pend_req", {31'b0, mem_req}, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_req_drop", {31'b0, mem_req}, 0);
        chk("async_pc", {16'b0, pc}, 0);
        run = 1'b0;
        ext_ack = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("late_ack_idle", {30'b0, mem_req, halted}, 0);
        chk("late_ack_pc", {16'b0, pc}, 0);
        ext_ack = 1'b0;
        ack_dly = 0;
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
